// File: rtl/cache_refill_ctrl.sv
// Miss-handling controller: latches a victim way, writes the victim line back
// when dirty, then refills the missing line word by word into that way.
module cache_refill_ctrl #(
    parameter int NUM_WAY    = 2,
    parameter int LINE_WORDS = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          miss_valid,
    output logic                          miss_ready,
    input  logic [ADDR_WIDTH-1:0]         miss_addr,
    output logic                          repl_en,
    input  logic [NUM_WAY-1:0]            replace_way,
    output logic [NUM_WAY-1:0]            victim_way,
    input  logic                          victim_dirty,
    input  logic [ADDR_WIDTH-1:0]         victim_line_addr,
    output logic [$clog2(LINE_WORDS)-1:0] victim_word_idx,
    input  logic [DATA_WIDTH-1:0]         victim_word,
    output logic                          wr_req,
    output logic [ADDR_WIDTH-1:0]         wr_addr,
    input  logic                          wr_ready,
    output logic                          wr_data_valid,
    output logic [DATA_WIDTH-1:0]         wr_data,
    output logic                          wr_last,
    input  logic                          wr_data_ready,
    output logic                          rd_req,
    output logic [ADDR_WIDTH-1:0]         rd_addr,
    input  logic                          rd_ready,
    input  logic                          rd_data_valid,
    input  logic [DATA_WIDTH-1:0]         rd_data,
    output logic                          fill_en,
    output logic [NUM_WAY-1:0]            fill_way,
    output logic [$clog2(LINE_WORDS)-1:0] fill_word_idx,
    output logic [DATA_WIDTH-1:0]         fill_data,
    output logic                          refill_done
);
    // state   | meaning
    // IDLE    | ready for a miss; accept latches address and victim way
    // CHECK   | sample victim_dirty, pick write-back or refill
    // WB_ADDR | write-back address request
    // WB_DATA | stream victim line to memory
    // RD_ADDR | refill address request
    // RD_DATA | stream memory beats into the victim way
    // DONE    | one-cycle completion pulse
    typedef enum logic [2:0] {
        IDLE, CHECK, WB_ADDR, WB_DATA, RD_ADDR, RD_DATA, DONE
    } state_t;

    localparam int IDX_W = $clog2(LINE_WORDS);
    localparam int OFF_W = $clog2(LINE_WORDS * DATA_WIDTH / 8);
    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(LINE_WORDS - 1);
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'((64'd1 << OFF_W) - 64'd1);

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        cnt_q, cnt_d;
    logic [NUM_WAY-1:0]      victim_way_q, victim_way_d;
    logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
    logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        victim_way_d = victim_way_q;
        wr_addr_d    = wr_addr_q;
        rd_addr_d    = rd_addr_q;
        unique case (state_q)
            IDLE: begin
                if (miss_valid) begin
                    victim_way_d = replace_way;
                    rd_addr_d    = miss_addr & ~OFF_MASK;
                    state_d      = CHECK;
                end
            end
            CHECK: begin
                if (victim_dirty) begin
                    wr_addr_d = victim_line_addr;
                    state_d   = WB_ADDR;
                end else begin
                    state_d   = RD_ADDR;
                end
            end
            WB_ADDR: begin
                if (wr_ready) begin
                    cnt_d   = '0;
                    state_d = WB_DATA;
                end
            end
            WB_DATA: begin
                if (wr_data_ready) begin
                    cnt_d = cnt_q + IDX_W'(1);
                    if (cnt_q == LAST_IDX) state_d = RD_ADDR;
                end
            end
            RD_ADDR: begin
                if (rd_ready) begin
                    cnt_d   = '0;
                    state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                if (rd_data_valid) begin
                    cnt_d = cnt_q + IDX_W'(1);
                    if (cnt_q == LAST_IDX) state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            victim_way_q <= '0;
            wr_addr_q    <= '0;
            rd_addr_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            victim_way_q <= victim_way_d;
            wr_addr_q    <= wr_addr_d;
            rd_addr_q    <= rd_addr_d;
        end
    end

    // Data-path outputs are zeroed outside their owning state so reset leaves every output quiet.
    assign miss_ready      = (state_q == IDLE);
    assign repl_en         = miss_ready & miss_valid;
    assign victim_way      = victim_way_q;
    assign wr_req          = (state_q == WB_ADDR);
    assign wr_addr         = wr_addr_q;
    assign wr_data_valid   = (state_q == WB_DATA);
    assign victim_word_idx = wr_data_valid ? cnt_q : '0;
    assign wr_data         = wr_data_valid ? victim_word : '0;
    assign wr_last         = wr_data_valid && (cnt_q == LAST_IDX);
    assign rd_req          = (state_q == RD_ADDR);
    assign rd_addr         = rd_addr_q;
    assign fill_en         = (state_q == RD_DATA) && rd_data_valid;
    assign fill_way        = victim_way_q;
    assign fill_word_idx   = fill_en ? cnt_q : '0;
    assign fill_data       = fill_en ? rd_data : '0;
    assign refill_done     = (state_q == DONE);

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench for cache_refill_ctrl: a 2-way/4-word instance and a
// 4-way/8-word instance, with scoreboard queues for write-back and fill beats.
module tb_cache_refill_ctrl;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int total = 0;
    int passed = 0;
    int repl_pulses = 0;
    logic [63:0] wr_q[$];
    logic [63:0] fill_q[$];
    logic [63:0] fill8_q[$];

    logic          miss_valid, miss_ready, repl_en, victim_dirty;
    logic [AW-1:0] miss_addr, victim_line_addr, wr_addr, rd_addr;
    logic [1:0]    replace_way, victim_way, fill_way, victim_word_idx, fill_word_idx;
    logic [DW-1:0] victim_word, wr_data, rd_data, fill_data, vbase;
    logic          wr_req, wr_ready, wr_data_valid, wr_last, wr_data_ready;
    logic          rd_req, rd_ready, rd_data_valid, fill_en, refill_done;

    logic          b_miss_valid, b_miss_ready, b_repl_en, b_victim_dirty;
    logic [AW-1:0] b_miss_addr, b_victim_line_addr, b_wr_addr, b_rd_addr;
    logic [3:0]    b_replace_way, b_victim_way, b_fill_way;
    logic [2:0]    b_victim_word_idx, b_fill_word_idx;
    logic [DW-1:0] b_victim_word, b_wr_data, b_rd_data, b_fill_data, b_vbase;
    logic          b_wr_req, b_wr_ready, b_wr_data_valid, b_wr_last, b_wr_data_ready;
    logic          b_rd_req, b_rd_ready, b_rd_data_valid, b_fill_en, b_refill_done;

    // Cache data RAM model: victim word is base + index, available same cycle.
    assign victim_word   = vbase + DW'(victim_word_idx);
    assign b_victim_word = b_vbase + DW'(b_victim_word_idx);

    cache_refill_ctrl #(.NUM_WAY(2), .LINE_WORDS(4), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset),
        .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_addr(miss_addr),
        .repl_en(repl_en), .replace_way(replace_way), .victim_way(victim_way),
        .victim_dirty(victim_dirty), .victim_line_addr(victim_line_addr),
        .victim_word_idx(victim_word_idx), .victim_word(victim_word),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_ready(wr_ready),
        .wr_data_valid(wr_data_valid), .wr_data(wr_data), .wr_last(wr_last),
        .wr_data_ready(wr_data_ready),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready),
        .rd_data_valid(rd_data_valid), .rd_data(rd_data),
        .fill_en(fill_en), .fill_way(fill_way), .fill_word_idx(fill_word_idx),
        .fill_data(fill_data), .refill_done(refill_done)
    );

    cache_refill_ctrl #(.NUM_WAY(4), .LINE_WORDS(8), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut8 (
        .clk(clk), .reset(reset),
        .miss_valid(b_miss_valid), .miss_ready(b_miss_ready), .miss_addr(b_miss_addr),
        .repl_en(b_repl_en), .replace_way(b_replace_way), .victim_way(b_victim_way),
        .victim_dirty(b_victim_dirty), .victim_line_addr(b_victim_line_addr),
        .victim_word_idx(b_victim_word_idx), .victim_word(b_victim_word),
        .wr_req(b_wr_req), .wr_addr(b_wr_addr), .wr_ready(b_wr_ready),
        .wr_data_valid(b_wr_data_valid), .wr_data(b_wr_data), .wr_last(b_wr_last),
        .wr_data_ready(b_wr_data_ready),
        .rd_req(b_rd_req), .rd_addr(b_rd_addr), .rd_ready(b_rd_ready),
        .rd_data_valid(b_rd_data_valid), .rd_data(b_rd_data),
        .fill_en(b_fill_en), .fill_way(b_fill_way), .fill_word_idx(b_fill_word_idx),
        .fill_data(b_fill_data), .refill_done(b_refill_done)
    );

    always @(negedge clk) if (repl_en === 1'b1) repl_pulses++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ctrl"}, 64'({miss_ready, repl_en, wr_req, wr_data_valid, wr_last, rd_req,
                                 fill_en, refill_done, victim_way, victim_word_idx,
                                 fill_word_idx, fill_way}), 64'h8000);
        chk({tag, "_addr"}, {wr_addr, rd_addr}, 64'd0);
        chk({tag, "_data"}, {wr_data, fill_data}, 64'd0);
    endtask

    task automatic do_miss(input logic [AW-1:0] addr, input logic [1:0] way,
                           input logic dirty, input logic [AW-1:0] vline,
                           input logic [DW-1:0] wb, input logic [DW-1:0] rb,
                           input bit stall, input bit hold_valid,
                           input int abort_after, input int exp_lat);
        int cyc, rd_beats, fills, lat, stab_bad, busy_bad, order_bad;
        bit rd_phase, done, w_req_held, w_dat_held, r_req_held;
        logic [AW-1:0] held_wa, held_ra;
        logic [63:0] held_wd, e;
        cyc = 0; rd_beats = 0; fills = 0; lat = -1;
        stab_bad = 0; busy_bad = 0; order_bad = 0;
        rd_phase = 1'b0; done = 1'b0;
        w_req_held = 1'b0; w_dat_held = 1'b0; r_req_held = 1'b0;
        held_wa = '0; held_ra = '0; held_wd = '0;
        @(posedge clk); #1;
        miss_valid = 1'b1; miss_addr = addr; replace_way = way;
        victim_dirty = dirty; victim_line_addr = vline; vbase = wb;
        wr_ready = 1'b0; wr_data_ready = 1'b0; rd_ready = 1'b0; rd_data_valid = 1'b0;
        @(negedge clk);
        chk("accept_ready", 64'(miss_ready), 64'd1);
        chk("accept_repl_en", 64'(repl_en), 64'd1);
        chk("idle_no_done", 64'(refill_done), 64'd0);
        if (dirty) for (int i = 0; i < 4; i++) wr_q.push_back({31'd0, (i == 3), wb + DW'(i)});
        while (!done && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            if (!hold_valid) miss_valid = 1'b0;
            wr_ready      = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            wr_data_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            rd_ready      = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            rd_data_valid = 1'b0;
            rd_data       = 32'hDEAD_BEEF;
            if (rd_phase && rd_beats < 4) begin
                rd_data_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
                if (rd_data_valid) begin
                    rd_data = rb + DW'(rd_beats);
                    fill_q.push_back({28'd0, way, 2'(rd_beats), rd_data});
                    rd_beats++;
                end
            end
            @(negedge clk);
            if (cyc == 1) chk("victim_way", 64'(victim_way), 64'(way));
            if (miss_ready !== 1'b0 || repl_en !== 1'b0) busy_bad++;
            if (w_req_held && (wr_req !== 1'b1 || wr_addr !== held_wa)) stab_bad++;
            if (r_req_held && (rd_req !== 1'b1 || rd_addr !== held_ra)) stab_bad++;
            if (w_dat_held && (wr_data_valid !== 1'b1 || {31'd0, wr_last, wr_data} !== held_wd))
                stab_bad++;
            w_req_held = wr_req && !wr_ready;               held_wa = wr_addr;
            r_req_held = rd_req && !rd_ready;               held_ra = rd_addr;
            w_dat_held = wr_data_valid && !wr_data_ready;   held_wd = {31'd0, wr_last, wr_data};
            if (wr_req && wr_ready) chk("wr_addr", 64'(wr_addr), 64'(vline));
            if (wr_data_valid && wr_data_ready) begin
                e = (wr_q.size() != 0) ? wr_q.pop_front() : '1;
                chk("wb_beat", {31'd0, wr_last, wr_data}, e);
            end
            if (rd_req && wr_q.size() != 0) order_bad++;
            if (rd_req && rd_ready) begin
                chk("rd_addr", 64'(rd_addr), 64'(addr & ~32'hF));
                rd_phase = 1'b1;
            end
            if (fill_en) begin
                e = (fill_q.size() != 0) ? fill_q.pop_front() : '1;
                chk("fill_beat", {28'd0, fill_way, fill_word_idx, fill_data}, e);
                fills++;
            end
            if (refill_done) begin done = 1'b1; lat = cyc; end
            if (abort_after > 0 && fills == abort_after) return;
        end
        chk("refill_done_seen", 64'(done), 64'd1);
        if (exp_lat >= 0) chk("latency", 64'(lat), 64'(exp_lat));
        chk("fill_count", 64'(fills), 64'd4);
        chk("wb_beats_left", 64'(wr_q.size()), 64'd0);
        chk("fill_beats_left", 64'(fill_q.size()), 64'd0);
        chk("stable_while_stalled", 64'(stab_bad), 64'd0);
        chk("busy_outputs", 64'(busy_bad), 64'd0);
        chk("rd_after_wb", 64'(order_bad), 64'd0);
    endtask

    task automatic do_miss8(input logic [AW-1:0] addr, input logic [3:0] way,
                            input logic dirty, input int exp_lat);
        int cyc, rd_beats, wbeats, fills, lat;
        bit rd_phase;
        logic [63:0] e;
        cyc = 0; rd_beats = 0; wbeats = 0; fills = 0; lat = -1; rd_phase = 1'b0;
        @(posedge clk); #1;
        b_miss_valid = 1'b1; b_miss_addr = addr; b_replace_way = way;
        b_victim_dirty = dirty; b_victim_line_addr = 32'h0004_0000; b_vbase = 32'h300;
        while (lat < 0 && cyc < 200) begin
            if (cyc > 0) begin
                @(posedge clk); #1;
                b_miss_valid = 1'b0;
            end
            b_rd_data_valid = 1'b0;
            if (rd_phase && rd_beats < 8) begin
                b_rd_data_valid = 1'b1;
                b_rd_data = 32'h900 + DW'(rd_beats);
                fill8_q.push_back({25'd0, way, 3'(rd_beats), b_rd_data});
                rd_beats++;
            end
            @(negedge clk);
            if (cyc == 0) chk("b_accept", 64'({b_miss_ready, b_repl_en}), 64'd3);
            if (cyc == 1) chk("b_victim_way", 64'(b_victim_way), 64'(way));
            if (b_wr_req) chk("b_wr_addr", 64'(b_wr_addr), 64'h0004_0000);
            if (b_wr_data_valid) begin
                chk("b_wb_beat", {31'd0, b_wr_last, b_wr_data},
                    {31'd0, (wbeats == 7), 32'h300 + DW'(wbeats)});
                wbeats++;
            end
            if (b_rd_req) begin
                chk("b_rd_addr", 64'(b_rd_addr), 64'(addr & ~32'h1F));
                chk("b_rd_addr_low5", 64'(b_rd_addr[4:0]), 64'd0);
                rd_phase = 1'b1;
            end
            if (b_fill_en) begin
                e = (fill8_q.size() != 0) ? fill8_q.pop_front() : '1;
                chk("b_fill_beat", {25'd0, b_fill_way, b_fill_word_idx, b_fill_data}, e);
                fills++;
            end
            if (b_refill_done) lat = cyc;
            cyc++;
        end
        chk("b_latency", 64'(lat), 64'(exp_lat));
        chk("b_fill_count", 64'(fills), 64'd8);
        chk("b_wb_count", 64'(wbeats), 64'(dirty ? 8 : 0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        reset = 1'b1;
        miss_valid = 1'b0; miss_addr = '0; replace_way = '0; victim_dirty = 1'b0;
        victim_line_addr = '0; vbase = '0;
        wr_ready = 1'b0; wr_data_ready = 1'b0; rd_ready = 1'b0; rd_data_valid = 1'b0; rd_data = '0;
        b_miss_valid = 1'b0; b_miss_addr = '0; b_replace_way = '0; b_victim_dirty = 1'b0;
        b_victim_line_addr = '0; b_vbase = '0;
        b_wr_ready = 1'b1; b_wr_data_ready = 1'b1; b_rd_ready = 1'b1;
        b_rd_data_valid = 1'b0; b_rd_data = '0;
        #3;
        chk_reset("reset_initial");
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // clean miss, dirty miss, then random backpressure on a dirty miss
        do_miss(32'h1234, 2'b10, 1'b0, 32'h0,    32'h0,  32'hA0, 1'b0, 1'b0, 0, 7);
        do_miss(32'h4444, 2'b01, 1'b1, 32'h8000, 32'hB0, 32'hC0, 1'b0, 1'b0, 0, 12);
        do_miss(32'h5678, 2'b10, 1'b1, 32'h9000, 32'hB0, 32'hD0, 1'b1, 1'b0, 0, -1);

        // miss_valid held high across three back-to-back misses
        base = repl_pulses;
        do_miss(32'h0100, 2'b01, 1'b0, 32'h0,    32'h0,  32'h10, 1'b0, 1'b1, 0, 7);
        do_miss(32'h0200, 2'b10, 1'b1, 32'h7000, 32'hE0, 32'hF0, 1'b0, 1'b1, 0, 12);
        do_miss(32'h0300, 2'b01, 1'b0, 32'h0,    32'h0,  32'h20, 1'b0, 1'b1, 0, 7);
        miss_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("repl_pulses", 64'(repl_pulses - base), 64'd3);

        // reset after the second fill beat
        do_miss(32'h2468, 2'b10, 1'b0, 32'h0, 32'h0, 32'h50, 1'b0, 1'b0, 2, 7);
        reset = 1'b1;
        #1;
        chk_reset("reset_mid_refill");
        wr_q.delete();
        fill_q.delete();
        rd_data_valid = 1'b1;
        rd_data = 32'h77;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_reset_quiet", 64'({fill_en, wr_data_valid, refill_done, rd_req, wr_req}), 64'd0);
        end
        rd_data_valid = 1'b0;
        do_miss(32'h2468, 2'b10, 1'b0, 32'h0, 32'h0, 32'h60, 1'b0, 1'b0, 0, 7);

        // 4-way, 8-word instance
        do_miss8(32'h1234_567F, 4'b0100, 1'b0, 11);
        do_miss8(32'hABCD_EF00, 4'b1000, 1'b1, 20);
        do_miss8(32'h0000_0FE4, 4'b0001, 1'b0, 11);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
